// File: rtl/axi4_l1_mem.sv
// rtl/axi4_l1_mem.sv - AXI4 slave backed by a single-port word memory
//
// Ports
//   clk_i, rst_n                 : clock (rising edge), async active-low reset
//   s_aw* / s_awready            : write address channel
//   s_w*  / s_wready             : write data channel (byte strobes honoured)
//   s_b*  / s_bready             : write response channel (always OKAY)
//   s_ar* / s_arready            : read address channel
//   s_r*  / s_rready             : read data channel (1-cycle read latency)
module axi4_l1_mem #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 2,
  parameter int MEM_ADDR_BITS      = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] s_awaddr,
  input  logic [AXI4_ID_WIDTH-1:0]      s_awid,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic [1:0]                    s_awburst,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [AXI4_DATA_WIDTH-1:0]    s_wdata,
  input  logic [AXI4_DATA_WIDTH/8-1:0]  s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [AXI4_ID_WIDTH-1:0]      s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] s_araddr,
  input  logic [AXI4_ID_WIDTH-1:0]      s_arid,
  input  logic [7:0]                    s_arlen,
  input  logic [2:0]                    s_arsize,
  input  logic [1:0]                    s_arburst,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [AXI4_DATA_WIDTH-1:0]    s_rdata,
  output logic [AXI4_ID_WIDTH-1:0]      s_rid,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          s_rvalid,
  input  logic                          s_rready
);

  localparam int LANES = AXI4_DATA_WIDTH / 8;
  localparam int WORDS = 1 << MEM_ADDR_BITS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t                     state;
  logic                       idle_q;   // registered so ready cannot rise before the first edge after reset
  logic [AXI4_ID_WIDTH-1:0]   id_q;
  logic [MEM_ADDR_BITS-1:0]   addr_q;
  logic [7:0]                 cnt_q;    // beats remaining after the current one
  logic                       fixed_q;
  logic [AXI4_DATA_WIDTH-1:0] mem [WORDS];

  logic [MEM_ADDR_BITS-1:0]   rd_next;
  logic                       wr_en;
  logic                       unused_bits;

  // Size is ignored (beats are always full width) and upper address bits alias.
  assign unused_bits = ^{s_awaddr, s_araddr, s_awsize, s_arsize};

  // A simultaneous AW/AR request goes to the write; mask ARREADY combinationally
  // so the read is never handshaken in the same cycle.
  assign s_awready = idle_q;
  assign s_arready = idle_q & ~s_awvalid;

  assign wr_en   = s_wready & s_wvalid;
  assign rd_next = fixed_q ? addr_q : addr_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (s_wstrb[b]) mem[addr_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idle_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      fixed_q  <= 1'b0;
      s_wready <= 1'b0;
      s_bvalid <= 1'b0;
      s_bid    <= '0;
      s_bresp  <= RESP_OKAY;
      s_rvalid <= 1'b0;
      s_rlast  <= 1'b0;
      s_rdata  <= '0;
      s_rid    <= '0;
      s_rresp  <= RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          idle_q <= 1'b1;
          if (idle_q && s_awvalid) begin
            idle_q   <= 1'b0;
            id_q     <= s_awid;
            addr_q   <= s_awaddr[MEM_ADDR_BITS+1:2];
            cnt_q    <= s_awlen;
            fixed_q  <= (s_awburst == BURST_FIXED);
            s_wready <= 1'b1;
            state    <= S_WDATA;
          end else if (idle_q && s_arvalid) begin
            idle_q   <= 1'b0;
            addr_q   <= s_araddr[MEM_ADDR_BITS+1:2];
            cnt_q    <= s_arlen;
            fixed_q  <= (s_arburst == BURST_FIXED);
            s_rid    <= s_arid;
            s_rresp  <= RESP_OKAY;
            s_rdata  <= mem[s_araddr[MEM_ADDR_BITS+1:2]];
            s_rlast  <= (s_arlen == 8'd0);
            s_rvalid <= 1'b1;
            state    <= S_RDATA;
          end
        end
        S_WDATA: begin
          if (s_wvalid) begin
            // Early WLAST or exhausted length both close the burst.
            if (s_wlast || cnt_q == 8'd0) begin
              s_wready <= 1'b0;
              s_bvalid <= 1'b1;
              s_bid    <= id_q;
              s_bresp  <= RESP_OKAY;
              state    <= S_WRESP;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (!fixed_q) addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_WRESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            idle_q   <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (s_rready) begin
            if (s_rlast) begin
              s_rvalid <= 1'b0;
              s_rlast  <= 1'b0;
              idle_q   <= 1'b1;
              state    <= S_IDLE;
            end else begin
              addr_q  <= rd_next;
              s_rdata <= mem[rd_next];
              cnt_q   <= cnt_q - 8'd1;
              s_rlast <= (cnt_q == 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_l1_mem.sv
// tb/tb_axi4_l1_mem.sv - randomized self-checking bench for axi4_l1_mem
module tb_axi4_l1_mem;

  localparam int IW    = 2;
  localparam int WORDS = 1024;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   awaddr = '0, araddr = '0;
  logic [IW-1:0] awid = '0, arid = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = 3'd2, arsize = 3'd2;
  logic [1:0]    awburst = 2'b01, arburst = 2'b01;
  logic          awvalid = 1'b0, arvalid = 1'b0;
  logic          awready, arready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready = 1'b0;
  logic [31:0]   rdata;
  logic          rlast, rvalid, rready = 1'b0;

  always #5 clk_i = ~clk_i;

  axi4_l1_mem #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(IW), .MEM_ADDR_BITS(10)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .s_awaddr(awaddr), .s_awid(awid), .s_awlen(awlen), .s_awsize(awsize),
    .s_awburst(awburst), .s_awvalid(awvalid), .s_awready(awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wlast(wlast), .s_wvalid(wvalid), .s_wready(wready),
    .s_bid(bid), .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arid(arid), .s_arlen(arlen), .s_arsize(arsize),
    .s_arburst(arburst), .s_arvalid(arvalid), .s_arready(arready),
    .s_rdata(rdata), .s_rid(rid), .s_rresp(rresp), .s_rlast(rlast),
    .s_rvalid(rvalid), .s_rready(rready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_data  [WORDS];
  logic [3:0]  m_known [WORDS];
  logic [31:0] wbuf_d  [256];
  logic [3:0]  wbuf_s  [256];
  logic [31:0] last_rdata;

  // Reference: word touched by a beat, counted from the start address modulo memory size.
  function automatic int widx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int unsigned base, off;
    base = addr >> 2;
    off  = (burst == 2'b00) ? 0 : beat;
    return int'((base + off) % WORDS);
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        m_data[w][b*8 +: 8] = d[b*8 +: 8];
        m_known[w][b] = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] kmask(input int w);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = m_known[w][b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [IW-1:0] id);
    int t = 0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    #1;
    while (!awready && t < 100) begin @(negedge clk_i); #1; t++; end
    if (!awready) begin n_checks++; n_fail++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
    @(negedge clk_i);
    awvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input logic [IW-1:0] id);
    int t = 0;
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    #1;
    while (!arready && t < 100) begin @(negedge clk_i); #1; t++; end
    if (!arready) begin n_checks++; n_fail++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
    @(negedge clk_i);
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic last, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk_i);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    #1;
    while (!wready && t < 100) begin @(negedge clk_i); #1; t++; end
    if (!wready) begin n_checks++; n_fail++; $display("FAIL w_timeout: wready=%0b required 1", wready); end
    @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(input logic [IW-1:0] id, input int stall);
    int t = 0;
    bready = 1'b0;
    #1;
    while (!bvalid && t < 100) begin @(negedge clk_i); #1; t++; end
    n_checks++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b_valid: bvalid=%0b required 1", bvalid); end
    repeat (stall) begin
      @(negedge clk_i); #1;
      n_checks++;
      if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b_hold: bvalid=%0b required 1", bvalid); end
    end
    n_checks++;
    if (bid !== id || bresp !== 2'b00) begin
      n_fail++; $display("FAIL b_resp: bid=%0d bresp=%0d required bid=%0d bresp=0", bid, bresp, id);
    end
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    #1;
    n_checks++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL b_drop: bvalid=%0b required 0", bvalid); end
  endtask

  task automatic r_phase(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [IW-1:0] id, input int stall_beat, input int stall_len);
    for (int i = 0; i <= int'(len); i++) begin
      int          w, k;
      logic [31:0] mk, held_d;
      logic        held_l;
      #1;
      w  = widx(addr, burst, i);
      mk = kmask(w);
      n_checks++;
      if (rvalid !== 1'b1) begin n_fail++; $display("FAIL r_valid beat %0d: rvalid=%0b required 1", i, rvalid); end
      n_checks++;
      if ((rdata & mk) !== (m_data[w] & mk)) begin
        n_fail++; $display("FAIL r_data beat %0d: rdata=%08h required %08h (mask %08h)", i, rdata, m_data[w], mk);
      end
      n_checks++;
      if (rid !== id || rresp !== 2'b00 || rlast !== (i == int'(len))) begin
        n_fail++; $display("FAIL r_ctrl beat %0d: rid=%0d rresp=%0d rlast=%0b required %0d 0 %0b", i, rid, rresp, rlast, id, (i == int'(len)));
      end
      last_rdata = rdata;
      held_d = rdata; held_l = rlast;
      k = (i == stall_beat) ? stall_len : int'($urandom_range(0, 2));
      rready = 1'b0;
      repeat (k) begin
        @(negedge clk_i); #1;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== held_d || rid !== id || rlast !== held_l) begin
          n_fail++; $display("FAIL r_stall beat %0d: rvalid=%0b rdata=%08h rlast=%0b required 1 %08h %0b", i, rvalid, rdata, rlast, held_d, held_l);
        end
      end
      rready = 1'b1;
      @(negedge clk_i);
    end
    rready = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_end: rvalid=%0b required 0", rvalid); end
  endtask

  // Beats driven come from the rules: stop at WLAST or after len+1 beats.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [IW-1:0] id, input int last_idx);
    int nb;
    nb = (last_idx >= 0 && last_idx <= int'(len)) ? last_idx + 1 : int'(len) + 1;
    aw_phase(addr, len, burst, id);
    for (int i = 0; i < nb; i++) begin
      w_beat(wbuf_d[i], wbuf_s[i], (i == last_idx), int'($urandom_range(0, 1)));
      model_write(widx(addr, burst, i), wbuf_d[i], wbuf_s[i]);
    end
    b_phase(id, int'($urandom_range(0, 2)));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [IW-1:0] id, input int stall_beat, input int stall_len);
    ar_phase(addr, len, burst, id);
    r_phase(addr, len, burst, id, stall_beat, stall_len);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0 ||
        bid !== '0 || rid !== '0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: aw/ar/w/b/rvalid/rlast=%b bid=%0d rid=%0d bresp=%0d rresp=%0d rdata=%08h required all 0",
               tag, {awready, arready, wready, bvalid, rvalid, rlast}, bid, rid, bresp, rresp, rdata);
    end
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b0) begin n_fail++; $display("FAIL ready_early: awready=%0b required 0", awready); end
    @(negedge clk_i); #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: awready=%0b arready=%0b required 1 1", awready, arready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check_idle_outputs("reset_state");
    release_reset();
  endtask

  task automatic test_single();
    wbuf_d[0] = 32'hDEADBEEF; wbuf_s[0] = 4'hF;
    do_write(32'h10, 8'd0, 2'b01, 2'd1, 0);
    do_read(32'h10, 8'd0, 2'b01, 2'd1, -1, 0);
    n_checks++;
    if (last_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: rdata=%08h required deadbeef", last_rdata); end
  endtask

  task automatic test_burst16();
    for (int i = 0; i < 16; i++) begin wbuf_d[i] = i; wbuf_s[i] = 4'hF; end
    do_write(32'h100, 8'd15, 2'b01, 2'd2, 15);
    do_read(32'h100, 8'd15, 2'b01, 2'd2, -1, 0);
    n_checks++;
    if (last_rdata !== 32'd15) begin n_fail++; $display("FAIL burst16_last: rdata=%08h required 0000000f", last_rdata); end
  endtask

  task automatic test_strobe();
    wbuf_d[0] = 32'hFFFFFFFF; wbuf_s[0] = 4'hF;
    do_write(32'h20, 8'd0, 2'b01, 2'd0, 0);
    wbuf_d[0] = 32'h00000000; wbuf_s[0] = 4'h5;
    do_write(32'h20, 8'd0, 2'b01, 2'd0, 0);
    do_read(32'h20, 8'd0, 2'b01, 2'd3, -1, 0);
    n_checks++;
    if (last_rdata !== 32'hFF00FF00) begin n_fail++; $display("FAIL strobe_merge: rdata=%08h required ff00ff00", last_rdata); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] nd;
    wbuf_d[0] = 32'h11111111; wbuf_s[0] = 4'hF;
    do_write(32'h40, 8'd0, 2'b01, 2'd0, 0);
    nd = $urandom;
    araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arid = 2'd2; arvalid = 1'b1;
    awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awid = 2'd3; awvalid = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      n_fail++; $display("FAIL simul_ready: awready=%0b arready=%0b required 1 0", awready, arready);
    end
    @(negedge clk_i);
    awvalid = 1'b0;
    #1;
    n_checks++;
    if (arready !== 1'b0) begin n_fail++; $display("FAIL simul_ar_blocked: arready=%0b required 0", arready); end
    w_beat(nd, 4'hF, 1'b1, 0);
    model_write(widx(32'h40, 2'b01, 0), nd, 4'hF);
    b_phase(2'd3, 1);
    do_read(32'h40, 8'd0, 2'b01, 2'd2, -1, 0);
    n_checks++;
    if (last_rdata !== nd) begin n_fail++; $display("FAIL simul_postwrite: rdata=%08h required %08h", last_rdata, nd); end
  endtask

  task automatic test_rready_stall();
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    do_write(32'h200, 8'd7, 2'b01, 2'd1, 7);
    do_read(32'h200, 8'd7, 2'b01, 2'd1, 3, 5);
  endtask

  task automatic test_fixed_and_early_end();
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    do_write(32'h300, 8'd3, 2'b00, 2'd0, 3);
    do_read(32'h300, 8'd2, 2'b00, 2'd0, -1, 0);
    n_checks++;
    if (last_rdata !== wbuf_d[3]) begin n_fail++; $display("FAIL fixed_last: rdata=%08h required %08h", last_rdata, wbuf_d[3]); end
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = 32'hA0A0_0000 + i; wbuf_s[i] = 4'hF; end
    do_write(32'h380, 8'd7, 2'b01, 2'd1, 7);
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    do_write(32'h380, 8'd7, 2'b01, 2'd1, 2);
    do_read(32'h380, 8'd7, 2'b01, 2'd1, -1, 0);
    n_checks++;
    if (last_rdata !== 32'hA0A0_0007) begin n_fail++; $display("FAIL early_wlast_tail: rdata=%08h required a0a00007", last_rdata); end
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    do_write(32'h3C0, 8'd3, 2'b10, 2'd2, -1);
    do_read(32'h3C0, 8'd3, 2'b10, 2'd2, -1, 0);
  endtask

  task automatic test_alias();
    wbuf_d[0] = 32'hA5A5_5A5A; wbuf_s[0] = 4'hF;
    do_write(32'h1000, 8'd0, 2'b01, 2'd1, 0);
    do_read(32'h0000, 8'd0, 2'b01, 2'd1, -1, 0);
    n_checks++;
    if (last_rdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL alias_read: rdata=%08h required a5a55a5a", last_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 8; i++) begin wbuf_d[i] = 32'h5000_0000 + i; wbuf_s[i] = 4'hF; end
    do_write(32'h500, 8'd7, 2'b01, 2'd2, 7);
    aw_phase(32'h500, 8'd7, 2'b01, 2'd3);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = $urandom;
      w_beat(d, 4'hF, 1'b0, 0);
      model_write(widx(32'h500, 2'b01, i), d, 4'hF);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_burst");
    release_reset();
    do_read(32'h500, 8'd7, 2'b01, 2'd0, -1, 0);
    wbuf_d[0] = $urandom; wbuf_s[0] = 4'hF;
    do_write(32'h504, 8'd0, 2'b01, 2'd1, 0);
    do_read(32'h504, 8'd0, 2'b01, 2'd1, -1, 0);
  endtask

  task automatic test_max_burst();
    for (int i = 0; i < 256; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
    do_write(32'h800, 8'd255, 2'b01, 2'd3, 255);
    do_read(32'h800, 8'd255, 2'b01, 2'd3, 200, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [31:0]   a;
      logic [7:0]    len;
      logic [1:0]    burst;
      logic [IW-1:0] id;
      a     = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 10'($urandom), 2'b00};
      len   = 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 2));
      id    = IW'($urandom);
      for (int i = 0; i <= int'(len); i++) begin
        wbuf_d[i] = $urandom;
        wbuf_s[i] = (i == 0) ? 4'hF : 4'($urandom);
      end
      do_write(a, len, burst, id, ($urandom_range(0, 3) == 0) ? -1 : int'(len));
      do_read(a, len, burst, IW'($urandom), -1, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin m_data[i] = '0; m_known[i] = '0; end
    test_reset();
    test_single();
    test_burst16();
    test_strobe();
    test_simultaneous();
    test_rready_stall();
    test_fixed_and_early_end();
    test_alias();
    test_reset_mid_burst();
    test_max_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
